// File: rtl/vx_fpu_fma_sched_pkg.sv
// Shared FPU types and helpers for the FMA lane scheduler.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package VX_fpu_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_OUTPUT
  } fma_state_e;

  // FP32 constant 1.0, used as the multiplier for ADD/SUB
  localparam logic [31:0] ONE_F32 = 32'h3f800000;

  // Index width for n items; never zero so single-item cases still elaborate
  function automatic int batch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_fpu_fma_sched_opsel.sv
// Per-lane FMA operand/sign select: maps MADD/MSUB/NMADD/NMSUB/MUL/ADD/SUB onto a*b+c.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module vx_fpu_fma_opsel
  import VX_fpu_pkg::*;
(
  input  logic        is_madd,
  input  logic        is_sub,
  input  logic        is_neg,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic [31:0] datac,
  output logic [31:0] opa,
  output logic [31:0] opb,
  output logic [31:0] opc
);

  // MUL is the default; fused ops flip signs of a and c, ADD/SUB multiply a by 1.0
  always_comb begin
    opa = dataa;
    opb = datab;
    opc = 32'h0;
    if (is_madd) begin
      opa = {is_neg ^ dataa[31], dataa[30:0]};
      opc = {is_neg ^ is_sub ^ datac[31], datac[30:0]};
    end else if (!is_neg) begin
      opb = ONE_F32;
      opc = {is_sub ^ datab[31], datab[30:0]};
    end
  end

endmodule

// File: rtl/vx_fpu_fma_sched.sv
// Lane-serializing FMA front-end: issues non-empty lane batches to an external PE array, reassembles results.
// Latency: k issued batches give valid_out k+LATENCY+1 cycles after acceptance.
// Backpressure: one instruction at a time; output beat held until ready_out, PE array is never stalled mid-flight.
module vx_fpu_fma_sched
  import VX_fpu_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int NUM_PES   = 2,
  parameter int LATENCY   = 4,
  parameter int TAG_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic [NUM_LANES-1:0]          mask_in,
  input  logic [TAG_WIDTH-1:0]          tag_in,
  input  logic [2:0]                    frm,
  input  logic                          is_madd,
  input  logic                          is_sub,
  input  logic                          is_neg,
  input  logic [NUM_LANES-1:0][31:0]    dataa,
  input  logic [NUM_LANES-1:0][31:0]    datab,
  input  logic [NUM_LANES-1:0][31:0]    datac,
  output logic [NUM_LANES-1:0][31:0]    result,
  output logic [4:0]                    fflags,
  output logic [TAG_WIDTH-1:0]          tag_out,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic                          pe_enable,
  output logic [NUM_PES-1:0][31:0]      pe_a,
  output logic [NUM_PES-1:0][31:0]      pe_b,
  output logic [NUM_PES-1:0][31:0]      pe_c,
  output logic [2:0]                    pe_frm,
  input  logic [NUM_PES-1:0][31:0]      pe_result,
  input  logic [NUM_PES-1:0][4:0]       pe_fflags
);

  localparam int NB = NUM_LANES / NUM_PES;
  localparam int BW = batch_idx_w(NB);
  localparam int LW = batch_idx_w(NUM_LANES);

  fma_state_e state, state_nxt;

  logic [NUM_LANES-1:0][31:0] sel_a, sel_b, sel_c;
  logic [NUM_LANES-1:0][31:0] opa_q, opb_q, opc_q;
  logic [NUM_LANES-1:0][31:0] result_q;
  logic [NUM_LANES-1:0]       mask_q;
  logic [TAG_WIDTH-1:0]       tag_q;
  logic [2:0]                 frm_q;
  fflags_t                    fflags_q;

  logic [NB-1:0] act_in, pend_q, cur_oh;
  logic [BW-1:0] cur_idx;
  logic          issuing, last_issue, accept;

  logic [LATENCY-1:0]         trk_vld, trk_last;
  logic [LATENCY-1:0][BW-1:0] trk_idx;
  logic                       cap;
  logic [BW-1:0]              cap_idx;
  logic [4:0]                 cap_flags;

  function automatic logic [LW-1:0] lane_of(input logic [BW-1:0] b, input int p);
    return LW'(int'(b) * NUM_PES + p);
  endfunction

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_opsel
    vx_fpu_fma_opsel u_opsel (
      .is_madd (is_madd),
      .is_sub  (is_sub),
      .is_neg  (is_neg),
      .dataa   (dataa[l]),
      .datab   (datab[l]),
      .datac   (datac[l]),
      .opa     (sel_a[l]),
      .opb     (sel_b[l]),
      .opc     (sel_c[l])
    );
  end

  assign accept     = (state == ST_IDLE) && valid_in;
  assign issuing    = (state == ST_ISSUE);
  assign cur_oh     = pend_q & (~pend_q + NB'(1));
  assign last_issue = issuing && ((pend_q & ~cur_oh) == '0);
  assign cap        = pe_enable && trk_vld[LATENCY-1];
  assign cap_idx    = trk_idx[LATENCY-1];

  // Batches to issue: any non-empty slice; an empty mask still issues the top batch
  always_comb begin
    act_in = '0;
    for (int j = 0; j < NB; j++) act_in[j] = |mask_in[j*NUM_PES +: NUM_PES];
    if (mask_in == '0) act_in[NB-1] = 1'b1;
  end

  // Lowest pending batch is the one on the PE ports this cycle
  always_comb begin
    cur_idx = '0;
    for (int j = NB - 1; j >= 0; j--) if (pend_q[j]) cur_idx = BW'(j);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (valid_in) state_nxt = ST_ISSUE;
      ST_ISSUE:  if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (cap && trk_last[LATENCY-1]) state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (ready_out) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded handshakes; PE pipeline only moves while work is in flight
  always_comb begin
    ready_in  = (state == ST_IDLE);
    valid_out = (state == ST_OUTPUT);
    pe_enable = (state == ST_ISSUE) || (state == ST_DRAIN);
  end

  // PE operand drive for the current batch, zero otherwise
  always_comb begin
    pe_a = '0;
    pe_b = '0;
    pe_c = '0;
    if (issuing) begin
      for (int p = 0; p < NUM_PES; p++) begin
        pe_a[p] = opa_q[lane_of(cur_idx, p)];
        pe_b[p] = opb_q[lane_of(cur_idx, p)];
        pe_c[p] = opc_q[lane_of(cur_idx, p)];
      end
    end
  end

  // Flags of the returning batch, restricted to active lanes
  always_comb begin
    cap_flags = '0;
    for (int p = 0; p < NUM_PES; p++)
      if (mask_q[lane_of(cap_idx, p)]) cap_flags = cap_flags | pe_fflags[p];
  end

  // In-flight tracker mirrors the PE pipeline so results are matched to their batch
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_vld  <= '0;
      trk_last <= '0;
      trk_idx  <= '0;
    end else if (pe_enable) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        trk_vld[i]  <= trk_vld[i-1];
        trk_last[i] <= trk_last[i-1];
        trk_idx[i]  <= trk_idx[i-1];
      end
      trk_vld[0]  <= issuing;
      trk_last[0] <= last_issue;
      trk_idx[0]  <= cur_idx;
    end
  end

  // Latch the instruction on acceptance, retire issued batches, collect returning results
  always_ff @(posedge clk) begin
    if (reset) begin
      opa_q    <= '0;
      opb_q    <= '0;
      opc_q    <= '0;
      mask_q   <= '0;
      tag_q    <= '0;
      frm_q    <= '0;
      pend_q   <= '0;
      result_q <= '0;
      fflags_q <= '0;
    end else begin
      if (accept) begin
        opa_q    <= sel_a;
        opb_q    <= sel_b;
        opc_q    <= sel_c;
        mask_q   <= mask_in;
        tag_q    <= tag_in;
        frm_q    <= frm;
        pend_q   <= act_in;
        result_q <= '0;
        fflags_q <= '0;
      end
      if (issuing) pend_q <= pend_q & ~cur_oh;
      if (cap) begin
        for (int p = 0; p < NUM_PES; p++)
          if (mask_q[lane_of(cap_idx, p)]) result_q[lane_of(cap_idx, p)] <= pe_result[p];
        fflags_q <= fflags_t'(fflags_q | cap_flags);
      end
    end
  end

  assign result  = result_q;
  assign fflags  = fflags_q;
  assign tag_out = tag_q;
  assign pe_frm  = frm_q;

endmodule
